// File: rtl/fifo_read_drain.sv
// Burst-paced FIFO read drainer: reads TOTAL words in BURST_LEN bursts separated by GAP_CYCLES idle cycles.
// Defining DRAIN_CHECK_EN adds an incrementing-sequence data checker (err_cnt / err_flag).
module fifo_read_drain #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TOTAL      = 256
) (
    input  logic                r_clk,
    input  logic                r_rst,
    input  logic                start,
    input  logic                r_empty,
    input  logic [DATASIZE-1:0] r_data,
    output logic                r_en,
    output logic                rd_valid,
    output logic [DATASIZE-1:0] rd_data,
    output logic [15:0]         word_cnt,
    output logic [15:0]         err_cnt,
    output logic                err_flag,
    output logic                busy,
    output logic                done
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BEAT_W = 8;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(TOTAL - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_GAP  = BEAT_W'(GAP_CYCLES - 1);
    localparam bit                HAS_GAP   = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   r_gap;
    logic                r_pend;
    logic                w_rd;
    logic                w_start;
    logic                w_last_word;
    logic                w_last_beat;
    logic                w_gap_end;

    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_gap_end   = (r_gap == LAST_GAP);

    // State register
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read-enable decode; last word wins over end of burst
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_start = start;
                if (start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd = !r_empty;
                if (w_rd) begin
                    if (w_last_word) begin
                        w_state_nxt = S_DONE;
                    end else if (w_last_beat && HAS_GAP) begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_READ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word, beat and gap counters
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_word_cnt <= '0;
            r_beat     <= '0;
            r_gap      <= '0;
        end else if (w_start) begin
            r_word_cnt <= '0;
            r_beat     <= '0;
            r_gap      <= '0;
        end else begin
            if (w_rd) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                r_beat     <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            end
            if (r_state == S_GAP) begin
                r_gap <= w_gap_end ? '0 : r_gap + BEAT_W'(1);
            end
        end
    end

    // Capture pipeline: FIFO data arrives one cycle after r_en, strobed out the cycle after that
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_pend   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            r_pend   <= w_rd;
            rd_valid <= r_pend;
            if (r_pend) begin
                rd_data <= r_data;
            end
        end
    end

`ifdef DRAIN_CHECK_EN
    logic [DATASIZE-1:0] r_expect;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_err_flag;

    // Expected value always follows the last received word, so one bad word costs one error
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_expect   <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (w_start) begin
            r_expect   <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (r_pend) begin
            if (r_data != r_expect) begin
                r_err_flag <= 1'b1;
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
            r_expect <= r_data + DATASIZE'(1);
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
`else
    assign err_cnt  = '0;
    assign err_flag = 1'b0;
`endif

    assign r_en     = w_rd;
    assign word_cnt = r_word_cnt;
    assign busy     = (r_state == S_READ) || (r_state == S_GAP);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_fifo_read_drain.sv
// Directed bench for fifo_read_drain: a FIFO model feeds the default instance, an always-full source feeds a
// BURST_LEN=1 / GAP_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_fifo_read_drain;
    localparam int unsigned MEM = 2048;

    logic        r_clk = 1'b0;
    logic        r_rst, start, start_f;
    logic        r_en, rd_valid, err_flag, busy, done;
    logic        r_empty;
    logic [7:0]  r_data = 8'd0;
    logic [7:0]  rd_data;
    logic [15:0] word_cnt, err_cnt;

    logic        r_en_f, rd_valid_f, err_flag_f, busy_f, done_f;
    logic [7:0]  r_data_f = 8'd0;
    logic [7:0]  cnt_f = 8'd0;
    logic [7:0]  rd_data_f;
    logic [15:0] word_cnt_f, err_cnt_f;

    logic [7:0]  mem [MEM];
    logic [10:0] wr_ptr = 11'd0;
    logic [10:0] rd_ptr = 11'd0;

    int checks = 0;
    int errors = 0;

    int          mon_ren, mon_valid, mon_order, gap_len, gaps4, gaps_other;
    logic [7:0]  mon_exp;

    always #5 r_clk = ~r_clk;

    // FIFO model with registered read data
    assign r_empty = (wr_ptr == rd_ptr);
    always @(posedge r_clk) begin
        if (r_en) begin
            r_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 11'd1;
        end
    end

    // Never-empty source for the fast instance
    always @(posedge r_clk) begin
        if (r_en_f) begin
            r_data_f <= cnt_f;
            cnt_f    <= cnt_f + 8'd1;
        end
    end

    fifo_read_drain u_dut (
        .r_clk(r_clk), .r_rst(r_rst), .start(start), .r_empty(r_empty), .r_data(r_data),
        .r_en(r_en), .rd_valid(rd_valid), .rd_data(rd_data), .word_cnt(word_cnt),
        .err_cnt(err_cnt), .err_flag(err_flag), .busy(busy), .done(done)
    );

    fifo_read_drain #(.DATASIZE(8), .BURST_LEN(1), .GAP_CYCLES(0), .TOTAL(20)) u_fast (
        .r_clk(r_clk), .r_rst(r_rst), .start(start_f), .r_empty(1'b0), .r_data(r_data_f),
        .r_en(r_en_f), .rd_valid(rd_valid_f), .rd_data(rd_data_f), .word_cnt(word_cnt_f),
        .err_cnt(err_cnt_f), .err_flag(err_flag_f), .busy(busy_f), .done(done_f)
    );

    // Activity monitor sampled on the falling edge
    always @(negedge r_clk) begin
        if (r_en) mon_ren++;
        if (rd_valid) begin
            mon_valid++;
            if (rd_data !== mon_exp) mon_order++;
            mon_exp = mon_exp + 8'd1;
        end
        if (busy && !r_en) begin
            gap_len++;
        end else if (r_en) begin
            if (gap_len == 4) gaps4++;
            else if (gap_len != 0) gaps_other++;
            gap_len = 0;
        end
    end

    task automatic step();
        @(posedge r_clk);
        #2;
    endtask

    task automatic mon_clear();
        mon_ren = 0; mon_valid = 0; mon_order = 0;
        gap_len = 0; gaps4 = 0; gaps_other = 0;
        mon_exp = 8'd0;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 11'd1;
    endtask

    task automatic reset_and_flush();
        r_rst = 1'b0; start = 1'b0; start_f = 1'b0;
        step(); step();
        wr_ptr = rd_ptr;
        r_rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        r_rst = 1'b0; start = 1'b0; start_f = 1'b0;
        step(); step();
        checks++; if (r_en !== 1'b0)      begin errors++; $display("FAIL reset_r_en got %b want 0", r_en); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
        checks++; if (err_cnt !== 16'd0)  begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (err_flag !== 1'b0)  begin errors++; $display("FAIL reset_err_flag got %b want 0", err_flag); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        r_rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_full_drain();
        bit finished = 1'b0;
        wr_ptr = rd_ptr;
        for (int i = 0; i < 256; i++) push(8'(i));
        mon_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 1000 && !finished; i++) begin
            if (done === 1'b1) finished = 1'b1;
            else step();
        end
        checks++; if (!finished) begin errors++; $display("FAIL drain_timeout got done=%b want 1 within 1000 cycles", done); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (mon_valid != 256) begin errors++; $display("FAIL drain_rd_valid_count got %0d want 256", mon_valid); end
        checks++; if (mon_ren != 256)   begin errors++; $display("FAIL drain_r_en_count got %0d want 256", mon_ren); end
        checks++; if (mon_order != 0)   begin errors++; $display("FAIL drain_data_order got %0d bad words want 0", mon_order); end
        checks++; if (gaps4 != 15)      begin errors++; $display("FAIL drain_gap4_count got %0d want 15", gaps4); end
        checks++; if (gaps_other != 0)  begin errors++; $display("FAIL drain_gap_other got %0d want 0", gaps_other); end
        checks++; if (word_cnt !== 16'd256) begin errors++; $display("FAIL drain_word_cnt got %0d want 256", word_cnt); end
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL drain_done got %b want 1", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL drain_busy got %b want 0", busy); end
        checks++; if (r_en !== 1'b0)    begin errors++; $display("FAIL drain_r_en_idle got %b want 0", r_en); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL drain_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_empty_wait();
        mon_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL empty_word_cnt_clear got %0d want 0", word_cnt); end
        for (int i = 0; i < 20; i++) step();
        checks++; if (mon_ren != 0)  begin errors++; $display("FAIL empty_r_en_count got %0d want 0", mon_ren); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %b want 1", busy); end
        push(8'h00);
        #1;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL empty_r_en_after_write got %b want 1", r_en); end
        step();
        checks++; if (r_en !== 1'b0)     begin errors++; $display("FAIL empty_single_r_en got %b want 0", r_en); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_early got %b want 0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL empty_valid_latency got %b want 1", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL empty_rd_data got %h want 00", rd_data); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL empty_word_cnt got %0d want 1", word_cnt); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_one_cycle got %b want 0", rd_valid); end
    endtask

    task automatic test_midrun_reset();
        bit hit = 1'b0;
        int v0;
        reset_and_flush();
        for (int i = 0; i < 256; i++) push(8'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (word_cnt === 16'd100) hit = 1'b1;
            else step();
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_reach100 got word_cnt=%0d want 100", word_cnt); end
        r_rst = 1'b0;
        step();
        checks++; if (r_en !== 1'b0)      begin errors++; $display("FAIL midreset_r_en got %b want 0", r_en); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL midreset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL midreset_rd_data got %h want 00", rd_data); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL midreset_word_cnt got %0d want 0", word_cnt); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_state got busy=%b done=%b want 0 0", busy, done); end
        r_rst = 1'b1;
        v0 = mon_valid;
        for (int i = 0; i < 5; i++) step();
        checks++; if (mon_valid != v0) begin errors++; $display("FAIL midreset_flushed got %0d extra rd_valid want 0", mon_valid - v0); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || word_cnt !== 16'd0) begin errors++; $display("FAIL restart_begin got busy=%b word_cnt=%0d want 1 0", busy, word_cnt); end
        step();
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL restart_word_cnt got %0d want 1", word_cnt); end
    endtask

    task automatic test_start_ignored();
        bit ready = 1'b0;
        logic [15:0] w0;
        for (int i = 0; i < 50 && !ready; i++) begin
            if (r_en === 1'b1) ready = 1'b1;
            else step();
        end
        checks++; if (!ready) begin errors++; $display("FAIL ignore_no_read got r_en=%b want 1", r_en); end
        w0 = word_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (word_cnt !== w0 + 16'd1) begin errors++; $display("FAIL ignore_word_cnt got %0d want %0d", word_cnt, w0 + 16'd1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
    endtask

    task automatic test_checker();
        logic [7:0] stream [5];
        stream[0] = 8'h00; stream[1] = 8'h01; stream[2] = 8'h02; stream[3] = 8'h55; stream[4] = 8'h56;
        reset_and_flush();
        for (int i = 0; i < 5; i++) push(stream[i]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL check_word_cnt got %0d want 5", word_cnt); end
        checks++; if (rd_data !== 8'h56)  begin errors++; $display("FAIL check_last_data got %h want 56", rd_data); end
`ifdef DRAIN_CHECK_EN
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL check_err_cnt got %0d want 1", err_cnt); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL check_err_flag got %b want 1", err_flag); end
`else
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL check_err_cnt_tied got %0d want 0", err_cnt); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL check_err_flag_tied got %b want 0", err_flag); end
`endif
    endtask

    task automatic test_back_to_back();
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++; if (r_en_f !== 1'b1) begin errors++; $display("FAIL b2b_r_en[%0d] got %b want 1", i, r_en_f); end
            checks++; if (word_cnt_f !== 16'(i)) begin errors++; $display("FAIL b2b_word_cnt[%0d] got %0d want %0d", i, word_cnt_f, i); end
            step();
        end
        checks++; if (done_f !== 1'b1)       begin errors++; $display("FAIL b2b_done got %b want 1", done_f); end
        checks++; if (r_en_f !== 1'b0)       begin errors++; $display("FAIL b2b_r_en_off got %b want 0", r_en_f); end
        checks++; if (busy_f !== 1'b0)       begin errors++; $display("FAIL b2b_busy got %b want 0", busy_f); end
        checks++; if (word_cnt_f !== 16'd20) begin errors++; $display("FAIL b2b_word_cnt_final got %0d want 20", word_cnt_f); end
        step();
        checks++; if (rd_valid_f !== 1'b1 || rd_data_f !== 8'd19) begin errors++; $display("FAIL b2b_last_word got valid=%b data=%0d want 1 19", rd_valid_f, rd_data_f); end
        checks++; if (err_cnt_f !== 16'd0 || err_flag_f !== 1'b0) begin errors++; $display("FAIL b2b_errors got %0d/%b want 0/0", err_cnt_f, err_flag_f); end
        step();
        checks++; if (rd_valid_f !== 1'b0) begin errors++; $display("FAIL b2b_valid_stop got %b want 0", rd_valid_f); end
    endtask

    initial begin
        r_rst = 1'b0; start = 1'b0; start_f = 1'b0;
        mon_clear();
        test_reset();
        test_full_drain();
        test_empty_wait();
        test_midrun_reset();
        test_start_ignored();
        test_checker();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
